// File: rtl/prv664_bus_pkg.sv
// Shared types and constants for the cache-to-memory bus arbiter.
// Holds field widths, the owner encoding, FSM states and the timeout default.
package prv664_bus_pkg;

    localparam int ID_W     = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int OPCODE_W = 5;
    localparam int FUNCT_W  = 3;
    localparam int ERR_W    = 2;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } bus_state_e;

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [ADDR_W-1:0]   addr;
        logic                ci;
        logic                wt;
        logic [OPCODE_W-1:0] opcode;
        logic [FUNCT_W-1:0]  funct;
        logic [DATA_W-1:0]   wdata;
        logic [ERR_W-1:0]    error;
    } bus_req_t;

endpackage

// File: rtl/cache_access_interface.sv
// Request channel between a cache and the memory side; full is the back-pressure signal.
interface cache_access_interface;
    import prv664_bus_pkg::*;

    logic                valid;
    logic [ID_W-1:0]     id;
    logic [ADDR_W-1:0]   addr;
    logic                ci;
    logic                wt;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic [DATA_W-1:0]   wdata;
    logic [ERR_W-1:0]    error;
    logic                full;

    modport master (output valid, id, addr, ci, wt, opcode, funct, wdata, error, input full);
    modport slave  (input valid, id, addr, ci, wt, opcode, funct, wdata, error, output full);
endinterface

// File: rtl/cache_return_interface.sv
// Return channel carrying read data and status back toward a cache.
interface cache_return_interface;
    import prv664_bus_pkg::*;

    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ERR_W-1:0]  error;
    logic              mmio;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, id, error, mmio, rdata);
    modport slave  (input valid, id, error, mmio, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arbiter2
    import prv664_bus_pkg::*;
(
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant  = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            grant = (prio_q == OWNER_D) ? 2'b10 : 2'b01;
        end
        // Priority moves to whoever just lost, so a persistent tie alternates.
        if (update && (grant != 2'b00)) begin
            prio_d = grant[OWNER_D] ? OWNER_I : OWNER_D;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            prio_q <= OWNER_D;
        end else begin
            prio_q <= prio_d;
        end
    end
endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates icache and dcache requests onto one memory port, one transaction at a time,
// forwarding the id-matched memory return (or a timeout error) to the requesting cache.
module cache_bus_arbiter
    import prv664_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    cache_access_interface.slave  icache_access,
    cache_return_interface.master icache_return,
    cache_access_interface.slave  dcache_access,
    cache_return_interface.master dcache_return,
    cache_access_interface.master mem_access,
    cache_return_interface.slave  mem_return
);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    bus_state_e        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              owner_q, owner_d;
    bus_req_t          req_q, req_d;
    bus_req_t          i_req, d_req;
    logic              ret_valid_i_q, ret_valid_i_d;
    logic              ret_valid_d_q, ret_valid_d_d;
    logic [ID_W-1:0]   ret_id_q, ret_id_d;
    logic [ERR_W-1:0]  ret_error_q, ret_error_d;
    logic              ret_mmio_q, ret_mmio_d;
    logic [DATA_W-1:0] ret_rdata_q, ret_rdata_d;
    logic [1:0]        arb_req, arb_grant;
    logic              idle;
    logic              mem_match;

    assign idle      = (state_q == IDLE);
    assign arb_req   = {dcache_access.valid, icache_access.valid};
    assign mem_match = mem_return.valid && (mem_return.id == req_q.id);

    rr_arbiter2 u_rr (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .req    (arb_req),
        .update (idle),
        .grant  (arb_grant)
    );

    assign icache_access.full = !idle || arb_grant[OWNER_D];
    assign dcache_access.full = !idle || arb_grant[OWNER_I];

    always_comb begin
        i_req.id     = icache_access.id;
        i_req.addr   = icache_access.addr;
        i_req.ci     = icache_access.ci;
        i_req.wt     = icache_access.wt;
        i_req.opcode = icache_access.opcode;
        i_req.funct  = icache_access.funct;
        i_req.wdata  = icache_access.wdata;
        i_req.error  = icache_access.error;
        d_req.id     = dcache_access.id;
        d_req.addr   = dcache_access.addr;
        d_req.ci     = dcache_access.ci;
        d_req.wt     = dcache_access.wt;
        d_req.opcode = dcache_access.opcode;
        d_req.funct  = dcache_access.funct;
        d_req.wdata  = dcache_access.wdata;
        d_req.error  = dcache_access.error;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        req_d         = req_q;
        ret_valid_i_d = 1'b0;
        ret_valid_d_d = 1'b0;
        ret_id_d      = ret_id_q;
        ret_error_d   = ret_error_q;
        ret_mmio_d    = ret_mmio_q;
        ret_rdata_d   = ret_rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_grant != 2'b00) begin
                    owner_d = arb_grant[OWNER_D] ? OWNER_D : OWNER_I;
                    req_d   = arb_grant[OWNER_D] ? d_req : i_req;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_access.full) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A match wins over a timeout that expires in the same cycle.
                if (mem_match || (cnt_q == TIMEOUT_LAST)) begin
                    state_d       = RESP;
                    ret_valid_i_d = (owner_q == OWNER_I);
                    ret_valid_d_d = (owner_q == OWNER_D);
                    ret_id_d      = req_q.id;
                    ret_error_d   = mem_match ? mem_return.error : ERR_W'(1);
                    ret_mmio_d    = mem_match ? mem_return.mmio : 1'b0;
                    ret_rdata_d   = mem_match ? mem_return.rdata : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ret_valid_i_q <= 1'b0;
            ret_valid_d_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ret_valid_i_q <= ret_valid_i_d;
            ret_valid_d_q <= ret_valid_d_d;
        end
    end

    // Payload registers are only meaningful alongside a valid, so they carry no reset.
    always_ff @(posedge clk_i) begin
        owner_q     <= owner_d;
        req_q       <= req_d;
        ret_id_q    <= ret_id_d;
        ret_error_q <= ret_error_d;
        ret_mmio_q  <= ret_mmio_d;
        ret_rdata_q <= ret_rdata_d;
    end

    assign mem_access.valid  = (state_q == ISSUE);
    assign mem_access.id     = req_q.id;
    assign mem_access.addr   = req_q.addr;
    assign mem_access.ci     = req_q.ci;
    assign mem_access.wt     = req_q.wt;
    assign mem_access.opcode = req_q.opcode;
    assign mem_access.funct  = req_q.funct;
    assign mem_access.wdata  = req_q.wdata;
    assign mem_access.error  = req_q.error;

    assign icache_return.valid = ret_valid_i_q;
    assign icache_return.id    = ret_id_q;
    assign icache_return.error = ret_error_q;
    assign icache_return.mmio  = ret_mmio_q;
    assign icache_return.rdata = ret_rdata_q;
    assign dcache_return.valid = ret_valid_d_q;
    assign dcache_return.id    = ret_id_q;
    assign dcache_return.error = ret_error_q;
    assign dcache_return.mmio  = ret_mmio_q;
    assign dcache_return.rdata = ret_rdata_q;
endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, cycles in WAIT without a matching memory return before an error return is issued; legal range 2..65535.
REQ-002 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 Port arst_i  input  1  reset, synchronous and active-high; sampled only on clk_i rising edge.
REQ-004 Port icache_access  cache_access_interface.slave  -  instruction-side request channel (valid, id, addr, ci, wt, opcode, funct, wdata, error in; full out).
REQ-005 Port icache_return  cache_return_interface.master  -  instruction-side return channel (valid, id, error, mmio, rdata out).
REQ-006 Port dcache_access  cache_access_interface.slave  -  data-side request channel, same fields as REQ-004.
REQ-007 Port dcache_return  cache_return_interface.master  -  data-side return channel, same fields as REQ-005.
REQ-008 Port mem_access  cache_access_interface.master  -  shared downstream request channel (full in).
REQ-009 Port mem_return  cache_return_interface.slave  -  shared downstream return channel.

Function
REQ-010 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-011 A request SHALL be accepted in IDLE when its valid=1 and its full=0; full SHALL be 1 for both requesters in every state except IDLE.
REQ-012 In IDLE, a single valid requester SHALL be granted; with both valid, the requester not granted last SHALL win; after reset, dcache SHALL win the first tie.
REQ-013 The loser of a tie SHALL see full=1 in that cycle.
REQ-014 On acceptance, all request fields and the owner bit SHALL be latched and the FSM SHALL go to ISSUE.
REQ-015 In ISSUE, mem_access.valid SHALL be 1 with the latched fields.
REQ-016 In ISSUE, the FSM SHALL go to WAIT when mem_access.full=0 and SHALL stay in ISSUE while full=1.
REQ-017 mem_access.valid SHALL be 0 in all states other than ISSUE.
REQ-018 In WAIT, a 16-bit counter SHALL increment each cycle, starting from 0 on entry.
REQ-019 In WAIT, mem_return.valid=1 with id equal to the latched id SHALL latch error, mmio and rdata and move the FSM to RESP.
REQ-020 In WAIT, a mem_return with a mismatching id SHALL be ignored.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 with no match, the FSM SHALL move to RESP with error='h1, mmio=0, rdata=0.
REQ-022 A match and a timeout in the same cycle SHALL be resolved in favour of the match.
REQ-023 In RESP, the owner's return.valid SHALL be 1 for exactly one cycle, carrying the latched id and data; the other return.valid SHALL be 0.
REQ-024 After RESP the FSM SHALL go to IDLE.
REQ-025 mem_return.valid in IDLE, ISSUE or RESP (including late returns after a timeout) SHALL be discarded.
REQ-026 Best case: acceptance at cycle T, mem_access.valid at T+1, memory return at T+1+k, upstream return.valid at T+2+k.
REQ-027 The next acceptance SHALL be possible at T+3+k.
REQ-028 Both return channels SHALL be registered outputs; both access full outputs SHALL be combinational from state and request valids.

Reset
REQ-029 While arst_i=1, the FSM SHALL go to IDLE, the counter SHALL be 0, and the round-robin pointer SHALL give dcache priority.
REQ-030 While arst_i=1, icache_return.valid, dcache_return.valid and mem_access.valid SHALL be 0, and any pending transaction SHALL be dropped without a return.
REQ-031 Return id, error, mmio and rdata need no reset value; valid bits are the only outputs requiring reset.

Structure
REQ-032 The FSM state enum, the owner encoding (OWNER_I=0, OWNER_D=1) and the TIMEOUT_CYCLES default SHALL live in shared package prv664_bus_pkg.
REQ-033 Two-requester round-robin selection SHALL be a sub-module rr_arbiter2 (req[1:0], update, grant[1:0], pointer register inside).
REQ-034 No other sub-modules SHALL be used.

Verification
REQ-035 Single icache read to addr 0x8000_0040, id 3, memory returns rdata 0x0123..EF after k=2 -> icache_return.valid at T+4 with id 3 and that rdata; dcache_return.valid stays 0.
REQ-036 icache and dcache valid in the same cycle after reset -> dcache granted first, icache next; with both continuously valid, grants alternate D,I,D,I.
REQ-037 mem_access.full held 1 for 5 cycles in ISSUE -> mem_access.valid held 1 for 6 cycles, fields stable, one transaction only.
REQ-038 With TIMEOUT_CYCLES=8 and no memory return -> owner return.valid with error='h1 and rdata 0 at 8 cycles after entering WAIT; a late return then arrives and is discarded.
REQ-039 Return with wrong id at WAIT+1, correct id at WAIT+3 -> only the correct return is forwarded.
REQ-040 arst_i asserted during WAIT -> next cycle all valids are 0, state is IDLE, and the subsequent memory return is discarded.
